video_stream_gen: RTL and testbench

- Video timing and test-pattern source that drives the luma/sync stream consumed by the 2D filter path (y, dv, hs, vs).
- Generates horizontal and vertical counters, blanking, sync pulses and an 8-bit luma pattern.
- Used as a stimulus source on hardware and in simulation, in place of the camera/HDMI input.

---
 rtl/video_stream_gen_if.sv | 12 +
 rtl/video_stream_gen.sv | 113 +++++++++++
 tb/tb_video_stream_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/video_stream_gen_if.sv
// video_stream_gen_if: luma/sync stream produced by video_stream_gen and consumed by the 2D filter path.
interface video_stream_gen_if;
   logic [7:0]  y;
   logic        dv;
   logic        hs;
   logic        vs;
   logic [10:0] x;
   logic [9:0]  line;
   logic        sof;
   modport master (output y, dv, hs, vs, x, line, sof);
   modport slave  (input  y, dv, hs, vs, x, line, sof);
endinterface

// File: rtl/video_stream_gen.sv
// video_stream_gen: video timing and test-pattern source with registered luma/sync outputs.
// Define VIDEO_STREAM_GEN_SCROLL_EN to scroll the patterns with an 8-bit frame counter.
module video_stream_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic [1:0]         pat_sel_i,
   input  logic [7:0]         const_i,
   video_stream_gen_if.master vid_o
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] H_HS0  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_HS1  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  V_VS0  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  V_VS1  = 10'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_params
      $error("video_stream_gen: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
   end

   typedef enum logic {IDLE, RUN} state_e;
   state_e      state_q, state_d;
   logic [10:0] h_q, h_d, x_q, x_d;
   logic [9:0]  v_q, v_d, line_q, line_d;
   logic [1:0]  pat_q, pat_d;
   logic [7:0]  cst_q, cst_d, y_q, y_d, scroll;
   logic        dv_q, dv_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d;
   logic        run, frame_end, load, chk;

`ifdef VIDEO_STREAM_GEN_SCROLL_EN
   logic [7:0] frame_q;
   always_ff @(posedge clk)
      frame_q <= rst ? '0 : (frame_end && en_i) ? frame_q + 8'd1 : frame_q;
   assign scroll = frame_q;
`else
   assign scroll = '0;
`endif

   always_comb begin
      run       = state_q == RUN;
      frame_end = run && h_q == H_LAST && v_q == V_LAST;
      state_d   = run ? ((frame_end && !en_i) ? IDLE : RUN) : (en_i ? RUN : IDLE);
      h_d       = (!run || h_q == H_LAST) ? '0 : h_q + 11'd1;
      v_d       = !run ? '0 : (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 10'd1;
      // pattern selection is captured on entry to the (0,0) counter state
      load      = state_d == RUN && h_d == '0 && v_d == '0;
      pat_d     = load ? pat_sel_i : pat_q;
      cst_d     = load ? const_i : cst_q;
      chk       = h_q[5] ^ v_q[5] ^ scroll[4];
      dv_d      = run && h_q < H_ACT && v_q < V_ACT;
      y_d       = !dv_d ? '0 :
                  (pat_q == 2'd0) ? h_q[7:0] + scroll :
                  (pat_q == 2'd1) ? v_q[7:0] + scroll :
                  (pat_q == 2'd2) ? {8{chk}} : cst_q;
      hs_d      = run && h_q >= H_HS0 && h_q < H_HS1;
      vs_d      = run && v_q >= V_VS0 && v_q < V_VS1;
      x_d       = h_q;
      line_d    = v_q;
      sof_d     = run && h_q == '0 && v_q == '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         h_q     <= '0;
         v_q     <= '0;
         pat_q   <= '0;
         cst_q   <= '0;
         y_q     <= '0;
         dv_q    <= 1'b0;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
         x_q     <= '0;
         line_q  <= '0;
         sof_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         pat_q   <= pat_d;
         cst_q   <= cst_d;
         y_q     <= y_d;
         dv_q    <= dv_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         x_q     <= x_d;
         line_q  <= line_d;
         sof_q   <= sof_d;
      end
   end

   assign vid_o.y    = y_q;
   assign vid_o.dv   = dv_q;
   assign vid_o.hs   = hs_q;
   assign vid_o.vs   = vs_q;
   assign vid_o.x    = x_q;
   assign vid_o.line = line_q;
   assign vid_o.sof  = sof_q;
endmodule

// File: tb/tb_video_stream_gen.sv
// tb_video_stream_gen: randomized bench comparing the stream against a frame-index reference model.
module tb_video_stream_gen;
   localparam int HA = 260, HFP = 3, HSY = 4, HBP = 5;
   localparam int VA = 6, VFP = 2, VSY = 2, VBP = 2;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FT = HT * VT;

   logic       clk = 1'b0, rst = 1'b1, en = 1'b0;
   logic [1:0] pat = '0;
   logic [7:0] cst = '0;
   int         nvec = 0, nerr = 0;

   video_stream_gen_if vif();
   video_stream_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut (
      .clk(clk), .rst(rst), .en_i(en), .pat_sel_i(pat), .const_i(cst), .vid_o(vif));

   always #5 clk = ~clk;

   wire [32:0] got = {vif.y, vif.dv, vif.hs, vif.vs, vif.x, vif.line, vif.sof};

   // model: running flag, pixel index within the frame, per-frame latched selection
   bit          m_run = 1'b0;
   int          m_t = 0;
   logic [1:0]  m_pat = '0;
   logic [7:0]  m_cst = '0;
   logic [32:0] exp_v = '0;

   function automatic logic [32:0] model_out(int t, logic [1:0] p, logic [7:0] c);
      int h = t % HT;
      int v = t / HT;
      bit act = h < HA && v < VA;
      logic [7:0] y;
      y = !act ? 8'h00 : p == 2'd0 ? 8'(h) : p == 2'd1 ? 8'(v) :
          p == 2'd2 ? (((h / 32) % 2 != (v / 32) % 2) ? 8'hFF : 8'h00) : c;
      return {y, act, (h >= HA + HFP && h < HA + HFP + HSY),
              (v >= VA + VFP && v < VA + VFP + VSY), 11'(h), 10'(v), (t == 0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         exp_v = '0; m_run = 1'b0; m_t = 0; m_pat = '0; m_cst = '0;
      end else if (!m_run) begin
         exp_v = '0;
         if (en) begin m_run = 1'b1; m_t = 0; m_pat = pat; m_cst = cst; end
      end else begin
         exp_v = model_out(m_t, m_pat, m_cst);
         if (m_t == FT - 1) begin
            m_t = 0; m_run = en;
            if (en) begin m_pat = pat; m_cst = cst; end
         end else m_t++;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0;
      repeat (3) tick();
      nvec++;
      if (got !== 33'b0) begin nerr++; $display("FAIL reset got=%h exp=0", got); end
      rst = 1'b0;
      tick();
      nvec++;
      if (got !== 33'b0) begin nerr++; $display("FAIL idle_hold got=%h exp=0", got); end
   endtask

   task automatic test_frame();
      int ndv = 0, nsof = 0;
      en = 1'b1; pat = 2'd0;
      for (int i = 0; i < FT + 20; i++) begin
         tick();
         nvec++;
         if (got !== exp_v) begin nerr++; $display("FAIL frame i=%0d got=%h exp=%h", i, got, exp_v); end
         if (i <= FT && vif.dv) ndv++;
         if (vif.sof) nsof++;
      end
      nvec++;
      if (ndv != HA * VA) begin nerr++; $display("FAIL dv_count got=%0d exp=%0d", ndv, HA * VA); end
      nvec++;
      if (nsof != 2) begin nerr++; $display("FAIL sof_count got=%0d exp=2", nsof); end
   endtask

   task automatic test_pattern_switch();
      int n = 0;
      pat = 2'd0;
      while (m_t != 3 * HT && n < 2 * FT) begin
         tick(); n++; nvec++;
         if (got !== exp_v) begin nerr++; $display("FAIL sw_wait got=%h exp=%h", got, exp_v); end
      end
      pat = 2'd3; cst = 8'h5A; n = 0;
      while (!vif.sof && n < FT + 5) begin
         tick(); n++; nvec++;
         if (got !== exp_v) begin nerr++; $display("FAIL sw_rest got=%h exp=%h", got, exp_v); end
      end
      nvec++;
      if (vif.sof !== 1'b1 || vif.y !== 8'h5A) begin
         nerr++; $display("FAIL pat_switch_sof sof=%b y=%h exp sof=1 y=5a", vif.sof, vif.y);
      end
      for (int i = 0; i < 2 * FT; i++) begin
         if ($urandom_range(0, 399) == 0) begin pat = 2'($urandom); cst = 8'($urandom); end
         tick(); nvec++;
         if (got !== exp_v) begin nerr++; $display("FAIL sw_rand i=%0d got=%h exp=%h", i, got, exp_v); end
      end
   endtask

   task automatic test_en_drop();
      int n = 0;
      while (m_t != 3 * HT && n < 2 * FT) begin
         tick(); n++; nvec++;
         if (got !== exp_v) begin nerr++; $display("FAIL drop_wait got=%h exp=%h", got, exp_v); end
      end
      en = 1'b0;
      for (int i = 0; i < FT + 30; i++) begin
         tick(); nvec++;
         if (got !== exp_v) begin nerr++; $display("FAIL drop i=%0d got=%h exp=%h", i, got, exp_v); end
      end
      nvec++;
      if (got !== 33'b0) begin nerr++; $display("FAIL idle_after_drop got=%h exp=0", got); end
      en = 1'b1;
      tick(); nvec++;
      if (got !== 33'b0) begin nerr++; $display("FAIL restart_lat got=%h exp=0", got); end
      tick(); nvec++;
      if (vif.sof !== 1'b1 || vif.dv !== 1'b1 || vif.x !== 11'd0 || vif.line !== 10'd0) begin
         nerr++; $display("FAIL restart_sof sof=%b dv=%b x=%0d line=%0d exp 1 1 0 0", vif.sof, vif.dv, vif.x, vif.line);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      while (m_t != 2 * HT + 50 && n < 2 * FT) begin
         tick(); n++; nvec++;
         if (got !== exp_v) begin nerr++; $display("FAIL rst_wait got=%h exp=%h", got, exp_v); end
      end
      rst = 1'b1;
      tick(); nvec++;
      if (got !== 33'b0) begin nerr++; $display("FAIL rst_mid got=%h exp=0", got); end
      rst = 1'b0;
      tick(); nvec++;
      if (got !== 33'b0) begin nerr++; $display("FAIL rst_idle got=%h exp=0", got); end
      tick(); nvec++;
      if (vif.sof !== 1'b1 || vif.x !== 11'd0 || vif.line !== 10'd0) begin
         nerr++; $display("FAIL rst_restart sof=%b x=%0d line=%0d exp 1 0 0", vif.sof, vif.x, vif.line);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4 * FT; i++) begin
         if ($urandom_range(0, 2499) == 0) en = ~en;
         if ($urandom_range(0, 299) == 0) begin pat = 2'($urandom); cst = 8'($urandom); end
         rst = $urandom_range(0, 9999) == 0;
         tick(); nvec++;
         if (got !== exp_v) begin nerr++; $display("FAIL random i=%0d got=%h exp=%h", i, got, exp_v); end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame();
      test_pattern_switch();
      test_en_drop();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
